// File: rtl/reval_reader_pkg.sv
// Shared definitions for the reval_reader block: FSM encoding, enable levels
// and the credit helper used to throttle entry reads.
package reval_reader_pkg;

    localparam int LEN_STATE = 3;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    typedef enum logic [LEN_STATE-1:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Entries already committed to the buffer once this cycle's pop leaves:
    // what is stored plus the read whose data is on the bus right now.
    function automatic logic [2:0] credits_used(input logic [1:0] count,
                                                input logic       pop,
                                                input logic       pend);
        return {1'b0, count} - {2'b00, pop} + {2'b00, pend};
    endfunction

endpackage

// File: rtl/reval_reader_fifo2.sv
// Two-entry FIFO whose head and non-empty flag are plain registers, so the
// downstream side never sees a combinational path from push or pop.
module reval_fifo2
    import reval_reader_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_din,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_dout,
    output logic              o_empty,
    output logic [1:0]        o_count
);

    logic [DATA_W-1:0] r_head;
    logic [DATA_W-1:0] r_tail;
    logic [1:0]        r_count;
    logic              r_valid;

    logic              w_push;
    logic              w_pop;
    logic [1:0]        w_count_next;

    always_comb begin
        w_pop        = i_pop && (r_count != 2'd0);
        w_push       = i_push && ((r_count != 2'd2) || w_pop);
        w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the data registers are reset too, because the head drives
            // a module output that must read zero straight out of reset.
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
            r_valid <= DISABLE;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values regardless of statement order.
            r_count <= w_count_next;
            r_valid <= (w_count_next != 2'd0);
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_head <= i_din;
                    else                 r_tail <= i_din;
                end
                2'b01: r_head <= r_tail;
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_head <= i_din;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_dout  = r_head;
    assign o_empty = ~r_valid;
    assign o_count = r_count;

endmodule

// File: rtl/reval_reader.sv
// Reads back a block of entries from memory starting at address 0 and streams
// them downstream through a 2-deep buffer under valid/ready flow control.
module reval_reader
    import reval_reader_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   length,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0] L_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t          r_state;
    logic [ADDR_W:0] r_len;
    logic [ADDR_W:0] r_addr;
    logic [ADDR_W:0] r_xfer;
    logic            r_pend;
    logic            r_busy;
    logic            r_done;

    logic            w_empty;
    logic [1:0]      w_count;
    logic            w_pop;
    logic            w_issue;
    logic            w_last_addr;
    logic            w_drained;
    logic [ADDR_W:0] w_xfer_after;

    // A read may issue when the slot freed by this cycle's pop is counted;
    // that keeps one transfer per cycle while never overfilling two entries.
    always_comb begin
        // NOTE: every combinational output gets a value on every path, so no
        // latch can be inferred.
        w_pop        = ~w_empty & out_ready;
        w_issue      = (r_state == S_READ) &&
                       (credits_used(w_count, w_pop, r_pend) < 3'd2);
        w_last_addr  = (r_addr == (r_len - L_ONE));
        w_xfer_after = r_xfer + {{ADDR_W{1'b0}}, w_pop};
        w_drained    = (w_xfer_after == r_len);
    end

    reval_fifo2 #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_pend),
        .i_din   (mem_rdata),
        .i_pop   (w_pop),
        .o_dout  (out_data),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_len   <= '0;
            r_addr  <= '0;
            r_xfer  <= '0;
            r_pend  <= DISABLE;
            r_busy  <= DISABLE;
            r_done  <= DISABLE;
        end else begin
            r_pend <= w_issue;
            if (w_issue) r_addr <= r_addr + L_ONE;
            if (w_pop)   r_xfer <= w_xfer_after;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_len   <= length;
                        r_busy  <= ENABLE;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    r_addr <= '0;
                    r_xfer <= '0;
                    if (r_len != '0) begin
                        r_state <= S_READ;
                    end else begin
                        r_state <= S_DONE;
                        r_done  <= ENABLE;
                    end
                end
                S_READ: begin
                    if (w_issue && w_last_addr) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    // All reads are issued, so matching the transfer count
                    // means the buffer is empty with nothing in flight.
                    if (w_drained) begin
                        r_state <= S_DONE;
                        r_done  <= ENABLE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= DISABLE;
                    r_busy  <= DISABLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_rd    = w_issue;
    assign mem_addr  = r_addr[ADDR_W-1:0];
    assign out_valid = ~w_empty;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_reval_reader.sv
// Directed bench for reval_reader: a one-cycle-latency memory model, a
// negedge monitor for stream bookkeeping, and hand-computed expectations.
module tb_reval_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [6:0] length;
    logic       mem_rd;
    logic [5:0] mem_addr;
    logic [7:0] mem_rdata = 8'h00;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_mis = 0;

    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    // Monitor bookkeeping, written only by the monitor process.
    logic [7:0] got [0:255];
    int got_n = 0, rd_n = 0, done_n = 0, viol_n = 0, addr_err_n = 0;
    int run_rd = 0, run_xf = 0;

    reval_reader u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .length    (length),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Entry memory: entry a holds 0x10 + a, returned the cycle after mem_rd.
    always @(posedge clk) begin
        if (mem_rd === 1'b1) mem_rdata <= 8'h10 + {2'b00, mem_addr};
    end

    always @(negedge clk) begin
        int pop;
        pop = (out_valid === 1'b1 && out_ready === 1'b1) ? 1 : 0;
        if (rst === 1'b1 || busy !== 1'b1) begin
            run_rd = 0;
            run_xf = 0;
        end
        if (mem_rd === 1'b1) begin
            rd_n++;
            if (mem_addr !== run_rd[5:0]) addr_err_n++;
            if ((run_rd - run_xf - pop) >= 2) viol_n++;
            run_rd++;
        end
        if (pop == 1) begin
            got[got_n] = out_data;
            got_n++;
            run_xf++;
        end
        if (done === 1'b1) done_n++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed running, expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Starts a run at the current drive point and waits (bounded) for done.
    task automatic run(input logic [6:0] len, input bit toggle, output int cycles);
        start  = 1'b1;
        length = len;
        if (!toggle) out_ready = 1'b1;
        cycles = 0;
        for (int i = 1; i <= 400; i++) begin
            cyc();
            start  = 1'b0;
            length = 7'd3;
            if (toggle) out_ready = pat[(i - 1) % 4];
            @(negedge clk);
            if (done === 1'b1) begin
                cycles = i;
                break;
            end
        end
        check("run_done_seen", {31'd0, cycles != 0}, 32'd1);
        out_ready = 1'b1;
        cyc();
    endtask

    initial begin
        logic [7:0] t1_rd, t1_val, t1_done, t1_busy, t2_busy, t2_done;
        int c, b_got, b_rd, b_done;

        rst = 1'b1; start = 1'b0; length = 7'd0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_mem_rd",    {31'd0, mem_rd},    32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_done",      {31'd0, done},      32'd0);
        check("rst_out_data",  {24'd0, out_data},  32'd0);
        check("rst_mem_addr",  {26'd0, mem_addr},  32'd0);
        cyc();
        rst = 1'b0;
        cyc();

        // length=4, ready high: first read the cycle after START, data two
        // cycles after that, four back-to-back transfers, done next cycle.
        t1_rd   = 8'b0000_1111;
        t1_val  = 8'b0011_1100;
        t1_done = 8'b0100_0000;
        t1_busy = 8'b0111_1111;
        start = 1'b1; length = 7'd4; out_ready = 1'b1;
        cyc();
        start = 1'b0; length = 7'd0;
        @(negedge clk);
        check("t1_start_busy",  {31'd0, busy},   32'd1);
        check("t1_start_rd",    {31'd0, mem_rd}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            cyc();
            @(negedge clk);
            check($sformatf("t1_rd_%0d", k),    {31'd0, mem_rd},    {31'd0, t1_rd[k]});
            if (t1_rd[k]) check($sformatf("t1_addr_%0d", k), {26'd0, mem_addr}, k);
            check($sformatf("t1_valid_%0d", k), {31'd0, out_valid}, {31'd0, t1_val[k]});
            if (t1_val[k]) check($sformatf("t1_data_%0d", k), {24'd0, out_data}, 16 + k - 2);
            check($sformatf("t1_done_%0d", k),  {31'd0, done},      {31'd0, t1_done[k]});
            check($sformatf("t1_busy_%0d", k),  {31'd0, busy},      {31'd0, t1_busy[k]});
        end
        cyc();

        // length=0 with start held: START, DONE, IDLE, START, DONE, then idle.
        t2_busy = 8'b0001_1011;
        t2_done = 8'b0001_0010;
        b_rd = rd_n;
        start = 1'b1; length = 7'd0;
        for (int k = 0; k < 7; k++) begin
            cyc();
            if (k == 4) start = 1'b0;
            @(negedge clk);
            check($sformatf("t2_busy_%0d", k),  {31'd0, busy},      {31'd0, t2_busy[k]});
            check($sformatf("t2_done_%0d", k),  {31'd0, done},      {31'd0, t2_done[k]});
            check($sformatf("t2_rd_%0d", k),    {31'd0, mem_rd},    32'd0);
            check($sformatf("t2_valid_%0d", k), {31'd0, out_valid}, 32'd0);
        end
        cyc();
        check("t2_no_reads", rd_n - b_rd, 0);

        // length=5 with out_ready cycling 1,0,0,1.
        b_got = got_n; b_rd = rd_n; b_done = done_n;
        run(7'd5, 1'b1, c);
        check("t3_xfers", got_n - b_got, 5);
        for (int j = 0; j < 5; j++)
            check($sformatf("t3_data_%0d", j), {24'd0, got[b_got + j]}, 16 + j);
        check("t3_reads", rd_n - b_rd, 5);
        check("t3_done_pulses", done_n - b_done, 1);
        check("t3_credit_viol", viol_n, 0);
        check("t3_addr_err", addr_err_n, 0);

        // Full memory, length=64: 64 reads, 64 back-to-back transfers.
        b_got = got_n; b_rd = rd_n; b_done = done_n;
        run(7'd64, 1'b0, c);
        check("t4_cycles_to_done", c, 68);
        check("t4_xfers", got_n - b_got, 64);
        for (int j = 0; j < 64; j++)
            check($sformatf("t4_data_%0d", j), {24'd0, got[b_got + j]}, 16 + j);
        check("t4_reads", rd_n - b_rd, 64);
        check("t4_done_pulses", done_n - b_done, 1);
        check("t4_addr_err", addr_err_n, 0);
        check("t4_credit_viol", viol_n, 0);

        // Reset in READ after two transfers, then a fresh length=2 run.
        b_got = got_n;
        start = 1'b1; length = 7'd8; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            start = 1'b0;
            if (got_n - b_got >= 2) break;
        end
        check("t5_two_xfers", got_n - b_got, 2);
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_mem_rd",    {31'd0, mem_rd},    32'd0);
        check("t5_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("t5_rst_busy",      {31'd0, busy},      32'd0);
        check("t5_rst_done",      {31'd0, done},      32'd0);
        check("t5_rst_out_data",  {24'd0, out_data},  32'd0);
        check("t5_rst_mem_addr",  {26'd0, mem_addr},  32'd0);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("t5_post_valid_0", {31'd0, out_valid}, 32'd0);
        cyc();
        @(negedge clk);
        check("t5_post_valid_1", {31'd0, out_valid}, 32'd0);
        check("t5_post_busy",    {31'd0, busy},      32'd0);
        cyc();
        b_got = got_n; b_done = done_n;
        run(7'd2, 1'b0, c);
        check("t5_cycles_to_done", c, 6);
        check("t5_xfers", got_n - b_got, 2);
        check("t5_data_0", {24'd0, got[b_got]},     32'h10);
        check("t5_data_1", {24'd0, got[b_got + 1]}, 32'h11);
        check("t5_done_pulses", done_n - b_done, 1);
        check("t5_addr_err", addr_err_n, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/reval_reader.md
REVAL_READER -- requirements
Module: reval_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of one stored entry.
REQ-002 SHALL have parameter ADDR_W, default 6, entry address width (max 2^ADDR_W entries).
REQ-003 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to read back a written set; sampled in IDLE only.
REQ-006 SHALL have port length  input  ADDR_W+1  number of entries to read; latched when start is accepted.
REQ-007 SHALL have port mem_rd  output  1  read strobe to entry memory.
REQ-008 SHALL have port mem_addr  output  ADDR_W  read address; valid while mem_rd high.
REQ-009 SHALL have port mem_rdata  input  DATA_W  read data; valid exactly 1 cycle after mem_rd.
REQ-010 SHALL have port out_data  output  DATA_W  entry presented downstream.
REQ-011 SHALL have port out_valid  output  1  out_data holds a valid entry.
REQ-012 SHALL have port out_ready  input  1  downstream accepts; transfer when out_valid and out_ready both high.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse after final entry transferred.

Function
REQ-015 SHALL implement FSM states IDLE, START, READ, DRAIN, DONE.
REQ-016 SHALL transition IDLE->START on start=1; START->READ if latched length>0, else START->DONE; READ->DRAIN when last address issued; DRAIN->DONE when buffer empty and no read in flight; DONE->IDLE unconditionally.
REQ-017 SHALL in START clear read address counter and transfer counter and latch length.
REQ-018 SHALL in READ assert mem_rd only when buffer occupancy plus in-flight reads < 2; address increments by 1 per issued read, starting at 0.
REQ-019 SHALL capture mem_rdata into a 2-entry FIFO on the cycle after each mem_rd; capture never overflows under any out_ready pattern.
REQ-020 SHALL drive out_valid = FIFO not empty and out_data = FIFO head, both registered (no combinational path from out_ready or mem_rdata).
REQ-021 SHALL deliver entries in address order, each exactly once, with no gaps or duplicates under arbitrary out_ready.
REQ-022 SHALL sustain one transfer per cycle when out_ready is held high.
REQ-023 SHALL, with start sampled at edge E, put ps=START after E, first mem_rd (addr 0) in cycle after, and first out_valid two cycles after that first mem_rd.
REQ-024 SHALL ignore start outside IDLE; length changes after acceptance have no effect.
REQ-025 SHALL treat length=2^ADDR_W as full memory read, issuing addresses 0..2^ADDR_W-1 without address wrap ambiguity (counter is ADDR_W+1 bits).
REQ-026 SHALL assert done for exactly one cycle (state DONE), including the length=0 case, with no mem_rd and no out_valid issued for length=0.
REQ-027 SHALL allow start to be accepted in the IDLE cycle immediately following DONE.

Reset
REQ-028 SHALL on rst force state IDLE and clear counters and FIFO; mem_rd, out_valid, busy, done all 0; out_data and mem_addr 0.
REQ-029 SHALL on rst mid-operation discard any in-flight read; mem_rdata arriving after reset release is not captured.

Structure
REQ-030 SHALL take LEN_STATE, ENABLE/DISABLE constants and state encodings from the shared ISA include.
REQ-031 SHALL contain one sub-module reval_fifo2 (2-entry DATA_W FIFO with push, pop, empty, count).

Verification
REQ-032 SHALL cover: length=4, out_ready=1, memory 0x10..0x13 -> out_data 0x10,0x11,0x12,0x13 on consecutive cycles, done 1 cycle after last transfer.
REQ-033 SHALL cover: length=5, out_ready toggling 1,0,0,1 repeat -> 5 ordered entries, mem_rd never issued with occupancy+in-flight=2.
REQ-034 SHALL cover: length=0 -> IDLE,START,DONE,IDLE; done pulse, zero mem_rd, zero out_valid.
REQ-035 SHALL cover: length=64 (ADDR_W=6) -> addresses 0..63 each once, 64 transfers, done pulse.
REQ-036 SHALL cover: rst asserted in READ after 2 transfers -> all outputs 0 next cycle, late mem_rdata not seen; new start length=2 yields correct 2 entries.
REQ-037 SHALL cover: start held high throughout run -> only one run per IDLE visit, back-to-back run begins immediately after DONE.
